// File: rtl/relu_backprop.sv
// ReLU backward gate: queues one derivative mask per forward sample and applies
// the masks, in order, to the returning gradient stream. Optional RELU_BP_DEADCNT_EN adds dead_count.
module relu_backprop #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 16,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  fwd_valid,
    output logic                  fwd_ready,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    input  logic                  grad_in_valid,
    output logic                  grad_in_ready,
    input  logic [DATA_WIDTH-1:0] grad_in_data,
    output logic                  grad_out_valid,
    input  logic                  grad_out_ready,
    output logic [DATA_WIDTH-1:0] grad_out_data,
`ifdef RELU_BP_DEADCNT_EN
    output logic [15:0]           dead_count,
`endif
    output logic [CW-1:0]         mask_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mask_mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rd_mask;

    assign full  = (mask_count == CW'(DEPTH));
    assign empty = (mask_count == '0);

    // rst gates the handshakes so nothing is accepted while reset is held
    assign fwd_ready     = rst & ~full;
    assign grad_in_ready = rst & ~empty & (~grad_out_valid | grad_out_ready);

    assign push    = fwd_valid & fwd_ready;
    assign pop     = grad_in_valid & grad_in_ready;
    assign rd_mask = mask_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_mem <= '0;
        end else if (push && !clear) begin
            mask_mem[wr_ptr] <= ~fwd_data[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mask_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   mask_count <= mask_count + CW'(1);
                2'b01:   mask_count <= mask_count - CW'(1);
                default: mask_count <= mask_count;
            endcase
        end
    end

    // Output register: loads on accept, holds under backpressure, drains otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grad_out_valid <= 1'b0;
            grad_out_data  <= '0;
        end else if (clear) begin
            grad_out_valid <= 1'b0;
            grad_out_data  <= '0;
        end else if (pop) begin
            grad_out_valid <= 1'b1;
            grad_out_data  <= rd_mask ? grad_in_data : '0;
        end else if (grad_out_ready) begin
            grad_out_valid <= 1'b0;
        end
    end

`ifdef RELU_BP_DEADCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dead_count <= '0;
        end else if (clear) begin
            dead_count <= '0;
        end else if (pop && !rd_mask && (dead_count != 16'hFFFF)) begin
            dead_count <= dead_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_relu_backprop.sv
// Directed self-checking bench for relu_backprop.
module tb_relu_backprop;

    localparam int DW = 12;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [DW-1:0] fwd_data;
    logic          grad_in_valid;
    logic          grad_in_ready;
    logic [DW-1:0] grad_in_data;
    logic          grad_out_valid;
    logic          grad_out_ready;
    logic [DW-1:0] grad_out_data;
    logic [CW-1:0] mask_count;
`ifdef RELU_BP_DEADCNT_EN
    logic [15:0]   dead_count;
`endif

    int total = 0;
    int bad   = 0;

    relu_backprop #(.DATA_WIDTH(DW), .DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_data       (fwd_data),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in_data   (grad_in_data),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out_data  (grad_out_data),
`ifdef RELU_BP_DEADCNT_EN
        .dead_count     (dead_count),
`endif
        .mask_count     (mask_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] a);
        fwd_valid = 1'b1;
        fwd_data  = a;
        tick();
        fwd_valid = 1'b0;
    endtask

    logic [DW-1:0] t1_a [4] = '{12'h005, 12'h800, 12'h000, 12'hFFF};
    logic [DW-1:0] t1_g [4] = '{12'h010, 12'h020, 12'h030, 12'h040};
    logic [DW-1:0] t1_e [4] = '{12'h010, 12'h000, 12'h030, 12'h000};

    initial begin
        rst = 1'b0; clear = 1'b0;
        fwd_valid = 1'b0; fwd_data = '0;
        grad_in_valid = 1'b0; grad_in_data = '0;
        grad_out_ready = 1'b1;
        #1;
        chk("rst_fwd_ready", 32'(fwd_ready), 0);
        chk("rst_gin_ready", 32'(grad_in_ready), 0);
        chk("rst_gout_valid", 32'(grad_out_valid), 0);
        chk("rst_gout_data", 32'(grad_out_data), 0);
        chk("rst_count", 32'(mask_count), 0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_fwd_ready", 32'(fwd_ready), 1);

        // 1: basic gating
        for (int i = 0; i < 4; i++) push_one(t1_a[i]);
        chk("t1_count", 32'(mask_count), 4);
        grad_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            grad_in_data = t1_g[i];
            #1;
            chk("t1_gin_ready", 32'(grad_in_ready), 1);
            tick();
            chk("t1_gout_valid", 32'(grad_out_valid), 1);
            chk("t1_gout_data", 32'(grad_out_data), 32'(t1_e[i]));
        end
        grad_in_valid = 1'b0;
        tick();
        chk("t1_drain_valid", 32'(grad_out_valid), 0);
        chk("t1_drain_count", 32'(mask_count), 0);

        // 2: fill to full, held 17th push, one pop reopens
        fwd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fwd_data = (i % 2 == 0) ? 12'h100 : 12'h900;
            tick();
        end
        chk("t2_count16", 32'(mask_count), 16);
        chk("t2_fwd_ready", 32'(fwd_ready), 0);
        fwd_data = 12'h123;
        tick();
        chk("t2_no_overwrite", 32'(mask_count), 16);
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1;
        grad_in_data = 12'h100;
        #1;
        chk("t2_pop_ready", 32'(grad_in_ready), 1);
        tick();
        grad_in_valid = 1'b0;
        #1;
        chk("t2_fwd_ready_again", 32'(fwd_ready), 1);
        chk("t2_count15", 32'(mask_count), 15);
        chk("t2_first_out", 32'(grad_out_data), 32'h100);
        grad_in_valid = 1'b1;
        for (int i = 1; i < 16; i++) begin
            grad_in_data = DW'(12'h100 + i);
            tick();
            chk("t2_drain_data", 32'(grad_out_data), (i % 2 == 0) ? 32'(12'h100 + i) : 0);
        end
        grad_in_valid = 1'b0;
        tick();
        chk("t2_empty", 32'(mask_count), 0);

        // 3: starvation, then same-cycle push is poppable only next cycle
        grad_in_valid = 1'b1;
        grad_in_data = 12'h7AB;
        #1;
        chk("t3_starve_ready", 32'(grad_in_ready), 0);
        tick(); tick();
        chk("t3_starve_valid", 32'(grad_out_valid), 0);
        fwd_valid = 1'b1;
        fwd_data = 12'h001;
        #1;
        chk("t3_same_cycle_ready", 32'(grad_in_ready), 0);
        tick();
        fwd_valid = 1'b0;
        #1;
        chk("t3_next_ready", 32'(grad_in_ready), 1);
        tick();
        chk("t3_out_data", 32'(grad_out_data), 32'h7AB);
        chk("t3_out_valid", 32'(grad_out_valid), 1);
        grad_in_valid = 1'b0;
        tick();

        // 4: backpressure, most-negative gradient passes unmodified
        push_one(12'h010); push_one(12'h020); push_one(12'h030);
        grad_out_ready = 1'b0;
        grad_in_valid = 1'b1;
        grad_in_data = 12'h111;
        tick();
        grad_in_data = 12'h222;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_bp_ready", 32'(grad_in_ready), 0);
            chk("t4_bp_valid", 32'(grad_out_valid), 1);
            chk("t4_bp_data", 32'(grad_out_data), 32'h111);
            tick();
        end
        chk("t4_bp_count", 32'(mask_count), 2);
        grad_out_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(grad_in_ready), 1);
        tick();
        chk("t4_out2", 32'(grad_out_data), 32'h222);
        grad_in_data = 12'h800;
        tick();
        chk("t4_out3", 32'(grad_out_data), 32'h800);
        chk("t4_out3_valid", 32'(grad_out_valid), 1);
        grad_in_valid = 1'b0;
        tick();
        chk("t4_final_valid", 32'(grad_out_valid), 0);
        chk("t4_final_count", 32'(mask_count), 0);

        // 5: sync clear, then async reset mid-stream
        fwd_valid = 1'b1;
        fwd_data = 12'h000;
        for (int i = 0; i < 9; i++) tick();
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1;
        grad_in_data = 12'h055;
        tick();
        grad_in_valid = 1'b0;
        grad_out_ready = 1'b0;
        chk("t5_pre_count", 32'(mask_count), 8);
        chk("t5_pre_valid", 32'(grad_out_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_clr_count", 32'(mask_count), 0);
        chk("t5_clr_valid", 32'(grad_out_valid), 0);
        chk("t5_clr_data", 32'(grad_out_data), 0);
        grad_out_ready = 1'b1;
        push_one(12'h004); push_one(12'h004);
        grad_in_valid = 1'b1;
        grad_in_data = 12'h066;
        tick();
        grad_in_valid = 1'b0;
        chk("t5_pre_rst_valid", 32'(grad_out_valid), 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(grad_out_valid), 0);
        chk("t5_rst_data", 32'(grad_out_data), 0);
        chk("t5_rst_count", 32'(mask_count), 0);
        chk("t5_rst_fwd_ready", 32'(fwd_ready), 0);
        tick();
        rst = 1'b1;
        tick();

`ifdef RELU_BP_DEADCNT_EN
        // 6: dead-gradient counter
        chk("t6_dead_init", 32'(dead_count), 0);
        push_one(12'h800); push_one(12'h001); push_one(12'hFFF);
        push_one(12'h900); push_one(12'h000);
        grad_in_valid = 1'b1;
        grad_in_data = 12'h00A;
        for (int i = 0; i < 5; i++) tick();
        grad_in_valid = 1'b0;
        tick();
        chk("t6_dead_count", 32'(dead_count), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_dead_clear", 32'(dead_count), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
